dmem_responder: RTL and testbench



---
 rtl/dmem_responder_pkg.sv | 40 ++++
 rtl/dmem_lane_align.sv | 49 ++++
 rtl/dmem_responder.sv | 134 +++++++++++++
 tb/tb_dmem_responder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder_pkg
// Brief   : Shared bus encodings, request record and FSM states for the
//           data-memory responder.
// Revision: 1.0
// ============================================================================
package dmem_responder_pkg;

    localparam int XLEN         = 32;
    localparam int TAG_MAX_BITS = 16;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } MEM_SIZE;

    typedef struct packed {
        BUS_COMMAND              command;
        MEM_SIZE                 size;
        logic [XLEN-1:0]         addr;
        logic [XLEN-1:0]         data;
        logic [TAG_MAX_BITS-1:0] tag;
    } DMEM_REQ;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } DMEM_STATE;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module  : dmem_lane_align
// Brief   : Byte-lane steering for sub-word loads and stores, plus the
//           alignment check for the requested access size.
// Revision: 1.0
// ============================================================================
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]      size,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] word,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_data,
    output logic [3:0]      byte_en,
    output logic [XLEN-1:0] store_word,
    output logic            misaligned
);

    logic [XLEN-1:0] w_shifted;

    always_comb begin
        w_shifted  = word >> {offset, 3'b000};
        load_data  = word;
        byte_en    = 4'b1111;
        store_word = store_data;
        misaligned = 1'b0;
        case (size)
            BYTE: begin
                load_data  = {24'b0, w_shifted[7:0]};
                byte_en    = 4'b0001 << offset;
                store_word = {4{store_data[7:0]}};
            end
            HALF: begin
                load_data  = {16'b0, w_shifted[15:0]};
                byte_en    = offset[1] ? 4'b1100 : 4'b0011;
                store_word = {2{store_data[15:0]}};
                misaligned = offset[0];
            end
            // WORD and the reserved encoding both behave as a full word
            default: begin
                misaligned = (offset != 2'b00);
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder
// Brief   : Single-outstanding data-memory responder with fixed latency,
//           sub-word access and error reporting.
// Revision: 1.0
// ============================================================================
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int MEM_WORDS   = 1024,
    parameter int MEM_LATENCY = 3,
    parameter int TAG_BITS    = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [1:0]          load2Dmem_command,
    input  logic [1:0]          load2Dmem_size,
    input  logic [XLEN-1:0]     load2Dmem_addr,
    input  logic [XLEN-1:0]     load2Dmem_data,
    output logic                Dmem2load_ready,
    output logic                Dmem2load_valid,
    output logic [TAG_BITS-1:0] Dmem2load_tag,
    output logic [XLEN-1:0]     Dmem2load_data,
    output logic                Dmem2load_error
);

    localparam int              c_AW       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [XLEN-1:0] c_BYTES    = XLEN'(MEM_WORDS * 4);
    localparam logic [3:0]      c_LAT_LOAD = 4'(MEM_LATENCY - 1);

    DMEM_STATE           r_state;
    logic [3:0]          r_lat;
    logic [TAG_BITS-1:0] r_tag_cnt;
    DMEM_REQ             r_req;
    logic [XLEN-1:0]     r_mem [MEM_WORDS];

    logic                w_accept;
    logic [c_AW-1:0]     w_index;
    logic [XLEN-1:0]     w_word;
    logic [XLEN-1:0]     w_load_data;
    logic [3:0]          w_be;
    logic [XLEN-1:0]     w_store_word;
    logic                w_misaligned;
    logic                w_error;
    logic                w_resp_edge;
    logic                w_commit;
    logic                w_unused_tag;

    assign w_accept    = Dmem2load_ready &&
                         (load2Dmem_command == BUS_LOAD || load2Dmem_command == BUS_STORE);
    assign w_index     = r_req.addr[c_AW+1:2];
    assign w_word      = r_mem[w_index];
    assign w_error     = w_misaligned || (r_req.addr >= c_BYTES);
    assign w_resp_edge = (r_state == WAIT) && (r_lat == 4'd0);
    assign w_commit    = w_resp_edge && (r_req.command == BUS_STORE) && !w_error;
    assign w_unused_tag = ^r_req.tag;

    dmem_lane_align u_align (
        .size       (r_req.size),
        .offset     (r_req.addr[1:0]),
        .word       (w_word),
        .store_data (r_req.data),
        .load_data  (w_load_data),
        .byte_en    (w_be),
        .store_word (w_store_word),
        .misaligned (w_misaligned)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= IDLE;
            r_lat           <= 4'd0;
            r_tag_cnt       <= '0;
            r_req           <= '0;
            Dmem2load_ready <= 1'b1;
            Dmem2load_valid <= 1'b0;
            Dmem2load_tag   <= '0;
            Dmem2load_data  <= '0;
            Dmem2load_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req.command   <= BUS_COMMAND'(load2Dmem_command);
                        r_req.size      <= (load2Dmem_size == 2'd3) ? WORD : MEM_SIZE'(load2Dmem_size);
                        r_req.addr      <= load2Dmem_addr;
                        r_req.data      <= load2Dmem_data;
                        r_req.tag       <= TAG_MAX_BITS'(r_tag_cnt);
                        r_tag_cnt       <= r_tag_cnt + 1'b1;
                        r_lat           <= c_LAT_LOAD;
                        Dmem2load_ready <= 1'b0;
                        r_state         <= WAIT;
                    end
                end
                // Counter reaching zero marks the response edge; the store commits on this same edge
                WAIT: begin
                    if (r_lat == 4'd0) begin
                        Dmem2load_valid <= 1'b1;
                        Dmem2load_tag   <= r_req.tag[TAG_BITS-1:0];
                        Dmem2load_error <= w_error;
                        Dmem2load_data  <= (r_req.command == BUS_LOAD && !w_error) ? w_load_data : '0;
                        r_state         <= RESP;
                    end else begin
                        r_lat <= r_lat - 4'd1;
                    end
                end
                RESP: begin
                    Dmem2load_valid <= 1'b0;
                    Dmem2load_ready <= 1'b1;
                    r_state         <= IDLE;
                end
                default: begin
                    Dmem2load_valid <= 1'b0;
                    Dmem2load_ready <= 1'b1;
                    r_state         <= IDLE;
                end
            endcase
        end
    end

    // Array contents are deliberately not reset
    always_ff @(posedge clock) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_index][8*i +: 8] <= w_store_word[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_responder
// Brief   : Directed self-checking bench for dmem_responder.
// Revision: 1.0
// ============================================================================
module tb_dmem_responder;

    localparam int LAT = 3;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  bus_cmd;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        rdy;
    logic        vld;
    logic [3:0]  rtag;
    logic [31:0] rdata;
    logic        rerr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    dmem_responder #(
        .MEM_WORDS   (1024),
        .MEM_LATENCY (LAT),
        .TAG_BITS    (4)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .load2Dmem_command (bus_cmd),
        .load2Dmem_size    (bus_size),
        .load2Dmem_addr    (bus_addr),
        .load2Dmem_data    (bus_wdata),
        .Dmem2load_ready   (rdy),
        .Dmem2load_valid   (vld),
        .Dmem2load_tag     (rtag),
        .Dmem2load_data    (rdata),
        .Dmem2load_error   (rerr)
    );

    task automatic check_value(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check_value({name, ".ready"}, 32'(rdy),   32'd1);
        check_value({name, ".valid"}, 32'(vld),   32'd0);
        check_value({name, ".tag"},   32'(rtag),  32'd0);
        check_value({name, ".data"},  rdata,      32'd0);
        check_value({name, ".error"}, 32'(rerr),  32'd0);
    endtask

    // One complete request: accept, latency, response fields, return to ready
    task automatic access(input string name, input logic [1:0] cmd, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] wdata, input bit hold,
                          input logic [31:0] exp_data, input logic [3:0] exp_tag, input bit exp_err);
        int waited = 0;
        int lat = 0;
        while (!rdy && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        check_value({name, ".ready_in"}, 32'(rdy), 32'd1);
        if (!rdy) return;
        bus_cmd   = cmd;
        bus_size  = sz;
        bus_addr  = addr;
        bus_wdata = wdata;
        @(posedge clock);
        @(negedge clock);
        check_value({name, ".ready_low"}, 32'(rdy), 32'd0);
        if (!hold) bus_cmd = 2'd0;
        while (!vld && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        bus_cmd = 2'd0;
        check_value({name, ".latency"}, 32'(lat), 32'(LAT));
        check_value({name, ".data"},  rdata,     exp_data);
        check_value({name, ".tag"},   32'(rtag), 32'(exp_tag));
        check_value({name, ".error"}, 32'(rerr), 32'(exp_err));
        @(negedge clock);
        check_value({name, ".valid_drop"}, 32'(vld), 32'd0);
        check_value({name, ".ready_back"}, 32'(rdy), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int pulses;
        logic [31:0] ref_word;
        logic [31:0] exp_b;
        reset_n   = 1'b0;
        bus_cmd   = 2'd0;
        bus_size  = 2'd0;
        bus_addr  = 32'd0;
        bus_wdata = 32'd0;
        repeat (2) @(negedge clock);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clock);

        access("st_w10",   2'd2, 2'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        4'd0, 1'b0);
        access("ld_b11",   2'd1, 2'd0, 32'h11, 32'h0,        1'b0, 32'h000000BE, 4'd1, 1'b0);
        access("ld_h12",   2'd1, 2'd1, 32'h12, 32'h0,        1'b0, 32'h0000DEAD, 4'd2, 1'b0);
        access("ld_w10",   2'd1, 2'd2, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 4'd3, 1'b0);
        access("st_b13",   2'd2, 2'd0, 32'h13, 32'hFFFFFF55, 1'b0, 32'h0,        4'd4, 1'b0);
        access("ld_w10b",  2'd1, 2'd2, 32'h10, 32'h0,        1'b0, 32'h55ADBEEF, 4'd5, 1'b0);
        access("err_h11",  2'd1, 2'd1, 32'h11, 32'h0,        1'b0, 32'h0,        4'd6, 1'b1);
        access("err_w12",  2'd1, 2'd2, 32'h12, 32'h0,        1'b0, 32'h0,        4'd7, 1'b1);
        access("err_oor",  2'd2, 2'd2, 32'h1000, 32'hAAAAAAAA, 1'b0, 32'h0,      4'd8, 1'b1);
        access("ld_w10c",  2'd1, 2'd2, 32'h10, 32'h0,        1'b0, 32'h55ADBEEF, 4'd9, 1'b0);

        // Reserved command encoding must be ignored
        bus_cmd  = 2'd3;
        bus_addr = 32'h10;
        pulses   = 0;
        repeat (6) begin
            @(negedge clock);
            if (vld) pulses++;
        end
        bus_cmd = 2'd0;
        check_value("cmd3.pulses", 32'(pulses), 32'd0);
        check_value("cmd3.ready",  32'(rdy),    32'd1);

        access("ld_sz3",   2'd1, 2'd3, 32'h10, 32'h0,        1'b0, 32'h55ADBEEF, 4'd10, 1'b0);
        access("st_w20",   2'd2, 2'd2, 32'h20, 32'hCAFEF00D, 1'b0, 32'h0,        4'd11, 1'b0);
        access("ld_w10d",  2'd1, 2'd2, 32'h10, 32'h0,        1'b0, 32'h55ADBEEF, 4'd12, 1'b0);

        // Abort a store two cycles after acceptance
        bus_cmd   = 2'd2;
        bus_size  = 2'd2;
        bus_addr  = 32'h20;
        bus_wdata = 32'h12345678;
        @(posedge clock);
        @(negedge clock);
        bus_cmd = 2'd0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        repeat (3) @(negedge clock);
        check_reset_outputs("rst_hold");
        reset_n = 1'b1;
        pulses  = 0;
        repeat (LAT + 3) begin
            @(negedge clock);
            if (vld) pulses++;
        end
        check_value("abort.pulses", 32'(pulses), 32'd0);
        access("ld_w20", 2'd1, 2'd2, 32'h20, 32'h0, 1'b0, 32'hCAFEF00D, 4'd0, 1'b0);

        // Tag wrap with the command held while the responder is busy
        ref_word = 32'h55ADBEEF;
        for (int i = 1; i <= 16; i++) begin
            exp_b = (ref_word >> (8 * (i % 4))) & 32'hFF;
            access($sformatf("tag%0d", i), 2'd1, 2'd0, 32'h10 + 32'(i % 4), 32'h0, 1'b1,
                   exp_b, 4'(i % 16), 1'b0);
        end

        access("st_h12",  2'd2, 2'd1, 32'h12, 32'h0000CAFE, 1'b0, 32'h0,        4'd1, 1'b0);
        access("ld_w10e", 2'd1, 2'd2, 32'h10, 32'h0,        1'b0, 32'hCAFEBEEF, 4'd2, 1'b0);
        access("st_h10",  2'd2, 2'd1, 32'h10, 32'hAAAA7777, 1'b0, 32'h0,        4'd3, 1'b0);
        access("ld_w10f", 2'd1, 2'd2, 32'h10, 32'h0,        1'b0, 32'hCAFE7777, 4'd4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
